transfer_hub: RTL and testbench
===============================

// Module: transfer_hub
// PURPOSE
//  Parametrised successor to the single-channel transfer center.
//  Deserialises MSB-first frames from the serial data line into DATA_W-bit words.
//  Tags each word with the scanner channel that sent it.
//  Buffers words in a DEPTH-entry FIFO.
//  Delivers words downstream on a valid/ready handshake.
//  Sits between the scanner serial links and the local storage/consumer.
// PARAMETERS
//  DATA_W   8  bits per frame word (>=2)
//  DEPTH    4  FIFO entries (power of two, >=2)
//  NUM_CH   2  scanner channels; CH_W = max(1,$clog2(NUM_CH))
// PORTS
//  clk        in   1          single clock; all state on rising edge
//  rst        in   1          asynchronous, active-low reset
//  ready_in   in   1          sender requests a transfer (frame start)
//  src_ch     in   CH_W       channel id of sender; sampled with ready_in
//  data_in    in   1          serial data, MSB first
//  ready_out  out  1          hub can accept a new frame
//  out_valid  out  1          head word available
//  out_ready  in   1          consumer accepts head word
//  out_data   out  DATA_W     head word
//  out_ch     out  CH_W       head word channel tag
//  level      out  $clog2(DEPTH+1)  FIFO occupancy
//  overrun    out  1          1-cycle pulse: ready_in seen while FIFO full
//  par_err    out  1          1-cycle pulse: parity mismatch (PARITY_EN only; else tied 0)
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, FIFO emptied.
//   Outputs: level=0, out_valid=0, out_data=0, out_ch=0, overrun=0, par_err=0.
//   Partial frame discarded.
//  ready_out = (state==IDLE) && !full; combinational, so it reads 1 while reset is held.
//  FSM states: IDLE, RECV, PAR (PARITY_EN only), DONE.
//   IDLE: ready_in && !full -> RECV; src_ch latched; bit_cnt=0.
//     ready_in && full -> stay IDLE; pulse overrun.
//   RECV: each edge shifts data_in into the LSB of the shift register; bit_cnt++.
//     After DATA_W samples -> PAR if PARITY_EN, else -> DONE.
//   PAR: sample one parity bit -> DONE.
//   DONE: push {ch,word} into FIFO (unless parity failed) -> IDLE.
//  Latency: ready_in high at edge T; data bits sampled at edges T+1..T+DATA_W.
//   Push at edge T+DATA_W+1 (+1 with PARITY_EN); out_valid high after that edge.
//  Full cannot be reached mid-frame: entry is gated on !full and there is one writer.
//   DONE never drops a word for lack of space.
//  Pop: out_valid && out_ready at an edge removes the head.
//   First-word fall-through: out_data/out_ch always show the head.
//   Pop while empty is ignored.
//  Simultaneous push and pop: both occur and level is unchanged; legal at any level, including full.
//  Pointers: log2(DEPTH) bits, natural wrap; full/empty derived from level.
//  ready_in is ignored outside IDLE.
// CONFIGURATION
//  TRANSFER_HUB_PARITY_EN defined:
//   one extra serial bit after the data, even parity over data+parity.
//   On mismatch the word is discarded in DONE and par_err pulses for 1 cycle in DONE.
//  Not defined: no PAR state; par_err tied 0; frame is exactly DATA_W bits.
// STRUCTURE
//  Package transfer_pkg: FSM state enum (IDLE/RECV/PAR/DONE); default DATA_W/DEPTH/NUM_CH constants.
//  Sub-module transfer_fifo: synchronous FIFO (WIDTH=CH_W+DATA_W, DEPTH), FWFT, level output.
//  Top: FSM, shifter and bit counter only.
// TESTING
//  1 Reset: hold rst=0 3 cycles, release -> level=0, out_valid=0, ready_out=1, no pulses.
//  2 Single frame: ready_in=1, src_ch=1, then bits 1,0,1,0,0,1,0,1
//    -> out_valid at edge T+9, out_data=8'hA5, out_ch=1, level=1.
//  3 Fill: 4 frames with out_ready=0 -> level=4, ready_out=0.
//    5th ready_in -> overrun pulse, state stays IDLE.
//  4 Drain while receiving: level=4, out_ready=1 every cycle, 5th frame sent
//    -> words popped in order; push/pop coincide with level unchanged; no loss.
//  5 Mid-frame reset: assert rst after 4 bits of 8'hFF -> level=0 and out_valid=0 at once.
//    Next full frame 8'h3C received correctly.
//  6 PARITY_EN: frame 8'h81 with parity bit 1 -> par_err pulse, level unchanged.
//    Same word with parity 0 -> stored.

Source files
------------

// File: rtl/transfer_pkg.sv
// Shared types and default sizing for the transfer hub slice.
package transfer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    PAR  = 2'd2,
    DONE = 2'd3
  } hubState_t;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 4;
  localparam int DEF_NUM_CH = 2;

  // Channel tag width; a single channel still needs one bit.
  function automatic int chWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/transfer_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy output.
module transfer_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  output logic [WIDTH-1:0] popData,
  output logic             valid,
  output logic             full,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic             empty;
  logic             doPush;
  logic             doPop;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign valid   = !empty;
  // A push at full is accepted only when a pop frees the head slot in the same cycle.
  assign doPop   = pop && !empty;
  assign doPush  = push && (!full || doPop);
  assign popData = empty ? '0 : mem[rdPtr];

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      level <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/transfer_hub.sv
// Serial-frame receiver tagging words by channel and buffering them in a FIFO.
// Optional parity bit: define TRANSFER_HUB_PARITY_EN.
module transfer_hub
  import transfer_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int NUM_CH = DEF_NUM_CH,
  localparam int CH_W  = chWidth(NUM_CH),
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ready_in,
  input  logic [CH_W-1:0]   src_ch,
  input  logic              data_in,
  output logic              ready_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CH_W-1:0]   out_ch,
  output logic [LVL_W-1:0]  level,
  output logic              overrun,
  output logic              par_err
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam int FW    = CH_W + DATA_W;

  hubState_t         state;
  hubState_t         nextState;
  logic [DATA_W-1:0] shiftReg;
  logic [CNT_W-1:0]  bitCnt;
  logic [CH_W-1:0]   chReg;
  logic              overrunQ;
  logic              full;
  logic              push;
  logic [FW-1:0]     popData;
`ifdef TRANSFER_HUB_PARITY_EN
  logic              parBad;
`endif

  assign ready_out = (state == IDLE) && !full;
  assign overrun   = overrunQ;
  assign out_ch    = popData[FW-1 -: CH_W];
  assign out_data  = popData[DATA_W-1:0];

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nextState;
  end

  // Next-state decode, FIFO push and parity-error pulse.
  always_comb begin
    nextState = state;
    case (state)
      IDLE: if (ready_in && !full) nextState = RECV;
`ifdef TRANSFER_HUB_PARITY_EN
      RECV: if (bitCnt == CNT_W'(DATA_W - 1)) nextState = PAR;
`else
      RECV: if (bitCnt == CNT_W'(DATA_W - 1)) nextState = DONE;
`endif
      PAR:  nextState = DONE;
      DONE: nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

`ifdef TRANSFER_HUB_PARITY_EN
  assign push    = (state == DONE) && !parBad;
  assign par_err = (state == DONE) && parBad;
`else
  assign push    = (state == DONE);
  assign par_err = 1'b0;
`endif

  // Datapath: channel latch, MSB-first shifter, bit counter, overrun pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shiftReg <= '0;
      bitCnt   <= '0;
      chReg    <= '0;
      overrunQ <= 1'b0;
`ifdef TRANSFER_HUB_PARITY_EN
      parBad   <= 1'b0;
`endif
    end else begin
      overrunQ <= (state == IDLE) && ready_in && full;
      case (state)
        IDLE: begin
          if (ready_in && !full) begin
            chReg  <= src_ch;
            bitCnt <= '0;
          end
        end
        RECV: begin
          shiftReg <= {shiftReg[DATA_W-2:0], data_in};
          bitCnt   <= bitCnt + 1'b1;
        end
`ifdef TRANSFER_HUB_PARITY_EN
        // Even parity: data bits plus parity bit must XOR to zero.
        PAR: parBad <= ^{shiftReg, data_in};
`endif
        default: ;
      endcase
    end
  end

  transfer_fifo #(
    .WIDTH(FW),
    .DEPTH(DEPTH)
  ) uFifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pushData ({chReg, shiftReg}),
    .pop      (out_ready),
    .popData  (popData),
    .valid    (out_valid),
    .full     (full),
    .level    (level)
  );

endmodule

// File: tb/tb_transfer_hub.sv
// Directed bench with scoreboard for transfer_hub (default sizing).
module tb_transfer_hub;

  logic       clk = 1'b0;
  logic       rst;
  logic       ready_in;
  logic [0:0] src_ch;
  logic       data_in;
  logic       ready_out;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [0:0] out_ch;
  logic [2:0] level;
  logic       overrun;
  logic       par_err;

  int total = 0;
  int bad   = 0;
  logic [8:0] sb[$];

  always #5 clk = ~clk;

  transfer_hub #(.DATA_W(8), .DEPTH(4), .NUM_CH(2)) dut (
    .clk(clk), .rst(rst), .ready_in(ready_in), .src_ch(src_ch),
    .data_in(data_in), .ready_out(ready_out), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch),
    .level(level), .overrun(overrun), .par_err(par_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Start a frame and shift all serial bits; ends with the FSM in DONE.
  task automatic sendBits(input logic [0:0] ch, input logic [7:0] word, input logic parBit);
    ready_in = 1'b1;
    src_ch   = ch;
    data_in  = 1'b0;
    cyc();
    ready_in = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      data_in = word[i];
      cyc();
    end
`ifdef TRANSFER_HUB_PARITY_EN
    data_in = parBit;
    cyc();
`else
    if (parBit) data_in = 1'b0;
`endif
    data_in = 1'b0;
  endtask

  task automatic sendFrame(input logic [0:0] ch, input logic [7:0] word);
    sb.push_back({ch, word});
    sendBits(ch, word, ^word);
    cyc();
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 20 && out_valid; i++) cyc();
    out_ready = 1'b0;
    chk("drain_empty", {31'd0, out_valid}, 32'd0);
    chk("drain_sb", sb.size(), 32'd0);
  endtask

  // Scoreboard: each head word accepted at the coming edge must match the oldest expectation.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("pop_unexpected", {23'd0, out_ch, out_data}, 32'h1ff);
      end else begin
        chk("pop_word", {23'd0, out_ch, out_data}, {23'd0, sb.pop_front()});
      end
    end
  end

  initial begin
    rst = 1'b0; ready_in = 1'b0; src_ch = '0; data_in = 1'b0; out_ready = 1'b0;
    // 1 reset
    repeat (3) cyc();
    chk("rst_ready_out_held", {31'd0, ready_out}, 32'd1);
    rst = 1'b1;
    cyc();
    chk("rst_level", {29'd0, level}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_ready_out", {31'd0, ready_out}, 32'd1);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    chk("rst_par_err", {31'd0, par_err}, 32'd0);
    chk("rst_data", {24'd0, out_data}, 32'd0);

    // 2 single frame, latency
    sb.push_back({1'b1, 8'hA5});
    sendBits(1'b1, 8'hA5, 1'b0);
    chk("lat_not_yet", {31'd0, out_valid}, 32'd0);
    cyc();
    chk("lat_valid", {31'd0, out_valid}, 32'd1);
    chk("single_data", {24'd0, out_data}, 32'hA5);
    chk("single_ch", {31'd0, out_ch}, 32'd1);
    chk("single_level", {29'd0, level}, 32'd1);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    chk("single_popped", {29'd0, level}, 32'd0);

    // 3 fill and overrun
    sendFrame(1'b0, 8'h11);
    sendFrame(1'b1, 8'h22);
    sendFrame(1'b0, 8'hC3);
    sendFrame(1'b1, 8'h7E);
    chk("fill_level", {29'd0, level}, 32'd4);
    chk("fill_ready_out", {31'd0, ready_out}, 32'd0);
    ready_in = 1'b1;
    cyc();
    ready_in = 1'b0;
    chk("overrun_pulse", {31'd0, overrun}, 32'd1);
    cyc();
    chk("overrun_clear", {31'd0, overrun}, 32'd0);
    chk("overrun_level", {29'd0, level}, 32'd4);

    // 4 drain while receiving
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    chk("pop_level3", {29'd0, level}, 32'd3);
    chk("idle_after_overrun", {31'd0, ready_out}, 32'd1);
    sb.push_back({1'b0, 8'h5A});
    sendBits(1'b0, 8'h5A, 1'b0);
    out_ready = 1'b1;
    cyc();
    chk("pushpop_level", {29'd0, level}, 32'd3);
    drain();
    chk("drain_level", {29'd0, level}, 32'd0);

    // 5 mid-frame reset
    sendFrame(1'b0, 8'h99);
    ready_in = 1'b1; src_ch = 1'b1;
    cyc();
    ready_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      data_in = 1'b1;
      cyc();
    end
    rst = 1'b0;
    #1;
    sb.delete();
    chk("mid_rst_level", {29'd0, level}, 32'd0);
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_ready_out", {31'd0, ready_out}, 32'd1);
    cyc();
    rst = 1'b1;
    data_in = 1'b0;
    cyc();
    sendFrame(1'b1, 8'h3C);
    chk("post_rst_level", {29'd0, level}, 32'd1);
    chk("post_rst_data", {24'd0, out_data}, 32'h3C);
    chk("post_rst_ch", {31'd0, out_ch}, 32'd1);
    drain();

`ifdef TRANSFER_HUB_PARITY_EN
    // 6 parity
    sendBits(1'b0, 8'h81, 1'b1);
    chk("par_err_pulse", {31'd0, par_err}, 32'd1);
    cyc();
    chk("par_err_clear", {31'd0, par_err}, 32'd0);
    chk("par_discard_level", {29'd0, level}, 32'd0);
    sendFrame(1'b0, 8'h81);
    chk("par_ok_level", {29'd0, level}, 32'd1);
    drain();
`else
    chk("par_err_tied", {31'd0, par_err}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
